entropy_reader: RTL and testbench

- Consumer end of the TRNG raw-bit stream. Samples the 1-bit entropy source output on a strobe and runs a repetition-count health test on the raw bits.
- Applies von Neumann debiasing, packs the debiased bits MSB-first into bytes and buffers them in a small FIFO.
- Serves bytes to the pin-level wrapper over a valid/ready read handshake.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/entropy_fifo.sv | 85 ++++++++
 rtl/entropy_reader.sv | 193 +++++++++++++++++++
 tb/tb_entropy_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG consumer path.
// Contents:
//   state_t         - entropy_reader control states
//   BYTE_W          - width of a packed output byte
//   DEF_FIFO_DEPTH  - default output FIFO depth (power of two, >= 2)
//   DEF_RCT_CUTOFF  - default repetition-count failure threshold (2..255)
package trng_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RCT_CUTOFF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        FAIL    = 2'd3
    } state_t;

endpackage

// File: rtl/entropy_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_data (accepted when not full, or full with a pop)
//   push_data   - byte to write
//   pop         - remove the head entry (ignored when empty)
//   flush       - empty the FIFO; wins over push and pop in the same cycle
//   head        - current head entry, 0 while empty
//   full, empty - occupancy flags
//   level       - number of stored entries
module entropy_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [BYTE_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [BYTE_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    logic do_push;
    logic do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // NOTE: storage has no reset; only pointers and level define validity,
    // so head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_ONE;
            end
        end
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/entropy_reader.sv
// Consumer end of the TRNG raw-bit stream: repetition-count health test,
// von Neumann debiasing, MSB-first byte packing and an output FIFO.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - collection enable
//   raw_bit      - raw entropy bit, qualified by raw_valid
//   raw_valid    - one-cycle strobe marking raw_bit valid
//   rd_data      - FIFO head byte (first-word fall-through)
//   rd_valid     - FIFO non-empty and not failed
//   rd_ready     - consumer accepts rd_data when rd_valid is high
//   fifo_level   - current FIFO occupancy
//   health_fail  - sticky repetition-count failure flag
//   clr_fail     - pulse clearing health_fail (only acts in FAIL)
module entropy_reader
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            raw_bit,
    input  logic                            raw_valid,
    output logic [BYTE_W-1:0]               rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            health_fail,
    input  logic                            clr_fail
);

    localparam int BC_W = $clog2(BYTE_W);

    localparam logic [7:0]      RCT_ONE   = 8'd1;
    localparam logic [7:0]      RCT_LIMIT = 8'(RCT_CUTOFF);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BYTE_W - 1);

    state_t            state_q,     state_d;
    logic              prev_bit_q,  prev_bit_d;
    logic [7:0]        rct_cnt_q,   rct_cnt_d;
    logic              phase_q,     phase_d;
    logic              first_bit_q, first_bit_d;
    logic [BYTE_W-1:0] shift_q,     shift_d;
    logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;

    logic              fifo_push;
    logic [BYTE_W-1:0] fifo_push_data;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_space;
    logic [7:0]        rct_next;
    logic [BYTE_W-1:0] shifted;

    assign rd_valid    = !fifo_empty && (state_q != FAIL);
    assign fifo_pop    = rd_valid && rd_ready;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign fifo_space  = !fifo_full || fifo_pop;
    assign health_fail = (state_q == FAIL);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d        = state_q;
        prev_bit_d     = prev_bit_q;
        rct_cnt_d      = rct_cnt_q;
        phase_d        = phase_q;
        first_bit_d    = first_bit_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        fifo_push      = 1'b0;
        fifo_push_data = shift_q;
        fifo_flush     = 1'b0;
        rct_next       = (raw_bit == prev_bit_q) ? rct_cnt_q + RCT_ONE : RCT_ONE;
        shifted        = {shift_q[BYTE_W-2:0], first_bit_q};

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (!en) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                end else if (raw_valid) begin
                    prev_bit_d = raw_bit;
                    rct_cnt_d  = rct_next;
                    if (rct_next == RCT_LIMIT) begin
                        // Flush on the entry edge so a concurrent pop is lost.
                        state_d    = FAIL;
                        fifo_flush = 1'b1;
                        bit_cnt_d  = '0;
                        phase_d    = 1'b0;
                        shift_d    = '0;
                    end else if (!phase_q) begin
                        first_bit_d = raw_bit;
                        phase_d     = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // Unequal pair emits its first bit (10 -> 1, 01 -> 0).
                        if (raw_bit != first_bit_q) begin
                            shift_d = shifted;
                            if (bit_cnt_q == BC_LAST) begin
                                bit_cnt_d      = '0;
                                fifo_push_data = shifted;
                                if (fifo_space) begin
                                    fifo_push = 1'b1;
                                end else begin
                                    state_d = HOLD;
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + BC_ONE;
                            end
                        end
                    end
                end
            end

            HOLD: begin
                // The completed byte waits in shift_q; strobes are dropped.
                phase_d = 1'b0;
                if (!en) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (fifo_space) begin
                    fifo_push = 1'b1;
                    state_d   = COLLECT;
                end
            end

            FAIL: begin
                fifo_flush = 1'b1;
                bit_cnt_d  = '0;
                phase_d    = 1'b0;
                shift_d    = '0;
                if (clr_fail) begin
                    rct_cnt_d = '0;
                    state_d   = en ? COLLECT : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_bit_q  <= 1'b0;
            rct_cnt_q   <= '0;
            phase_q     <= 1'b0;
            first_bit_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_bit_q  <= prev_bit_d;
            rct_cnt_q   <= rct_cnt_d;
            phase_q     <= phase_d;
            first_bit_q <= first_bit_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    entropy_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign rd_data = fifo_head;

endmodule

// File: tb/tb_entropy_reader.sv
// Self-checking bench for entropy_reader: directed scenarios followed by a
// randomized run, all checked every cycle against a queue-based model.
module tb_entropy_reader;

    localparam int DEPTH = 4;
    localparam int CUT   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_fail = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_level;
    logic       health_fail;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    entropy_reader #(
        .FIFO_DEPTH (DEPTH),
        .RCT_CUTOFF (CUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .fifo_level  (fifo_level),
        .health_fail (health_fail),
        .clr_fail    (clr_fail)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_RUN, M_WAIT, M_BAD} mode_t;

    mode_t    m_mode;
    bit [7:0] m_q[$];     // bytes readable by the consumer, head first
    int       m_acc;      // debiased bits gathered so far, as a number
    int       m_nbits;
    bit       m_phase;
    bit       m_first;
    bit       m_prev;
    int       m_run;      // length of the current run of identical raw bits
    bit [7:0] m_held;

    task automatic model_reset();
        m_mode = M_OFF; m_q.delete(); m_acc = 0; m_nbits = 0;
        m_phase = 0; m_first = 0; m_prev = 0; m_run = 0; m_held = 0;
    endtask

    task automatic model_step(input logic e, input logic v, input logic b,
                              input logic r, input logic c);
        bit       pop_now;
        bit       flushed;
        bit       do_push;
        bit [7:0] pv;
        pop_now = (m_q.size() != 0) && (m_mode != M_BAD) && r;
        flushed = 0;
        do_push = 0;
        pv      = 0;
        case (m_mode)
            M_OFF: if (e) m_mode = M_RUN;
            M_RUN: begin
                if (!e) begin
                    m_mode = M_OFF; m_nbits = 0; m_acc = 0; m_phase = 0;
                end else if (v) begin
                    m_run  = (b == m_prev) ? m_run + 1 : 1;
                    m_prev = b;
                    if (m_run == CUT) begin
                        m_mode = M_BAD; m_q.delete(); flushed = 1;
                        m_nbits = 0; m_acc = 0; m_phase = 0;
                    end else if (!m_phase) begin
                        m_first = b; m_phase = 1;
                    end else begin
                        m_phase = 0;
                        if (b != m_first) begin
                            m_acc = m_acc * 2 + int'(m_first);
                            m_nbits++;
                            if (m_nbits == 8) begin
                                pv = 8'(m_acc);
                                m_nbits = 0; m_acc = 0;
                                if (m_q.size() < DEPTH || pop_now) do_push = 1;
                                else begin m_held = pv; m_mode = M_WAIT; end
                            end
                        end
                    end
                end
            end
            M_WAIT: begin
                m_phase = 0;
                if (!e) m_mode = M_OFF;
                else if (m_q.size() < DEPTH || pop_now) begin
                    do_push = 1; pv = m_held; m_mode = M_RUN;
                end
            end
            M_BAD: if (c) begin m_run = 0; m_mode = e ? M_RUN : M_OFF; end
            default: m_mode = M_OFF;
        endcase
        if (pop_now && !flushed) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pv);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        bit ev;
        ev = (m_q.size() != 0) && (m_mode != M_BAD);
        check("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) check("rd_data", 32'(rd_data), 32'(m_q[0]));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("health_fail", 32'(health_fail), 32'(m_mode == M_BAD));
    endtask

    // One clock: drive at a falling edge, model the rising edge, check at the next falling edge.
    task automatic cyc(input logic e, input logic v, input logic b, input logic r, input logic c);
        en = e; raw_valid = v; raw_bit = b; rd_ready = r; clr_fail = c;
        @(posedge clk);
        model_step(e, v, b, r, c);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic pair(input logic a, input logic b, input logic r);
        cyc(1'b1, 1'b1, a, r, 1'b0);
        cyc(1'b1, 1'b1, b, r, 1'b0);
    endtask

    // Encode each data bit as an unequal pair so it survives debiasing.
    task automatic send_bits(input logic [7:0] d, input int n, input logic r);
        for (int i = 7; i > 7 - n; i--) pair(d[i], ~d[i], r);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        en = 1'b0; raw_valid = 1'b0; raw_bit = 1'b0; rd_ready = 1'b0; clr_fail = 1'b0;
        #1;
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_health", 32'(health_fail), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [7:0] b3[5];
    logic       e_r, v_r, b_r, r_r, c_r;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_model();

        // 1: pairs 10,01 x8 -> 0xAA
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin pair(1, 0, 0); pair(0, 1, 0); end
        check("t1_valid", 32'(rd_valid), 32'h1);
        check("t1_data", 32'(rd_data), 32'hAA);
        check("t1_level", 32'(fifo_level), 32'h1);

        // 2: discarded 00/11 pairs interleaved -> still one 0xAA
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pair(1, 0, 0); pair(0, 0, 0); pair(0, 1, 0); pair(1, 1, 0);
        end
        check("t2_data", 32'(rd_data), 32'hAA);
        check("t2_level", 32'(fifo_level), 32'h1);

        // 3: five bytes with no reads -> HOLD, then one pop admits the fifth
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            b3[k] = 8'($urandom);
            send_bits(b3[k], 8, 1'b0);
        end
        check("t3_level_full", 32'(fifo_level), 32'h4);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t3_level_hold", 32'(fifo_level), 32'h4);
        check("t3_head0", 32'(rd_data), 32'(b3[0]));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_level_after_pop", 32'(fifo_level), 32'h4);
        for (int k = 1; k < 5; k++) begin
            check("t3_order", 32'(rd_data), 32'(b3[k]));
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t3_drained", 32'(fifo_level), 32'h0);

        // 4: run of ones trips the health test, flushes, clr_fail recovers
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h96, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        check("t4_level_pre", 32'(fifo_level), 32'h2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_health", 32'(health_fail), 32'h1);
        check("t4_valid", 32'(rd_valid), 32'h0);
        check("t4_level", 32'(fifo_level), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_cleared", 32'(health_fail), 32'h0);
        send_bits(8'h5A, 8, 1'b0);
        check("t4_resume", 32'(rd_data), 32'h5A);

        // 5: reset mid-byte with three bytes queued
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        send_bits(8'h33, 8, 1'b0);
        send_bits(8'hF8, 5, 1'b0);
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'hC3, 8, 1'b0);
        check("t5_level", 32'(fifo_level), 32'h1);
        check("t5_data", 32'(rd_data), 32'hC3);

        // 6: en dropped mid-byte keeps queued bytes, partial byte discarded
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h96, 8, 1'b0);
        send_bits(8'h69, 8, 1'b0);
        send_bits(8'hFF, 5, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_level", 32'(fifo_level), 32'h2);
        check("t6_byte0", 32'(rd_data), 32'h96);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_byte1", 32'(rd_data), 32'h69);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pair(0, 1, 0);
        check("t6_level_new", 32'(fifo_level), 32'h1);
        check("t6_new_byte", 32'(rd_data), 32'h00);

        // 7: randomized traffic checked against the model every cycle
        async_reset();
        for (int i = 0; i < 1500; i++) begin
            e_r = ($urandom_range(0, 99) < 97);
            v_r = ($urandom_range(0, 99) < 70);
            b_r = 1'($urandom_range(0, 1));
            r_r = ($urandom_range(0, 99) < 40);
            c_r = ($urandom_range(0, 99) < 3);
            cyc(e_r, v_r, b_r, r_r, c_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
